mem_port_sched: RTL
===================

Name: mem_port_sched

Overview:
- Scheduler that shares the single-ported, variable-latency unified memory between instruction fetch (IF) and the data-memory stage (MEM) of the 16-bit processor.
- Driven by the decoder's MemRead/MemWrite/Halt controls.
- Serialises accesses, generates per-requester acks and stalls, drains the machine on HALT and traps memory timeouts.

Parameters:
- DATA_W, 16, memory word and address width.
- MAX_WAIT, 64, maximum cycles to wait for mem_ready; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held until if_ack
if_addr  in  DATA_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction, valid with if_ack
if_ack  out  1  one-cycle fetch completion pulse
d_rd  in  1  data read request (MemRead); held until d_ack
d_wr  in  1  data write request (MemWrite); held until d_ack
d_addr  in  DATA_W  data address (ALU result)
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid with d_ack
d_ack  out  1  one-cycle data completion pulse
halt_req  in  1  Halt decode; may be a pulse
mem_req  out  1  memory request; level, held until mem_ready
mem_wr  out  1  1=write, 0=read; stable while mem_req
mem_addr  out  DATA_W  stable while mem_req
mem_wdata  out  DATA_W  stable while mem_req
mem_rdata  in  DATA_W  read data, valid when mem_ready
mem_ready  in  1  memory completion, sampled only while mem_req=1
stall_if  out  1  if_req & ~if_ack (combinational)
stall_d  out  1  (d_rd|d_wr) & ~d_ack (combinational)
halted  out  1  machine drained and stopped
err  out  1  sticky timeout flag

Behaviour:
- Reset (async assert, sync release): state IDLE. All registered outputs are 0: mem_req, mem_wr, mem_addr, mem_wdata, if_rdata, d_rdata, if_ack, d_ack, halted, err. The halt latch and wait counter are also cleared.
- Reset during a transaction drops mem_req immediately; the memory must abandon the access.
- States: IDLE, D_WAIT, I_WAIT, HALT.
- IDLE, checked in priority order:
  - d_rd|d_wr: latch d_addr, d_wdata and mem_wr=d_wr; go to D_WAIT.
  - else if_req & ~halt_latched: latch if_addr, mem_wr=0; go to I_WAIT.
  - else if halt_latched: go to HALT.
- D_WAIT/I_WAIT:
  - mem_req=1 and the wait counter increments each cycle.
  - On mem_ready: mem_req=0 at the next edge; pulse d_ack or if_ack for one cycle; register mem_rdata into d_rdata (reads only) or if_rdata; return to IDLE; clear the counter.
  - d_rdata holds its previous value after a write.
- Latency: request seen in cycle 0, mem_req high in cycle 1. With mem_ready in cycle 1, the ack is in cycle 2. A new issue happens no earlier than the cycle after the ack, so there is a minimum of 1 idle cycle between transactions.
- Non-preemptive: a data request arriving during I_WAIT waits for the fetch to complete, then is served next, ahead of any fetch.
- d_rd & d_wr together: treated as a write.
- Once a transaction is issued, dropping the request does not cancel it; the ack still pulses.
- Timeout (MAX_WAIT>0): when the counter reaches MAX_WAIT without mem_ready, mem_req=0, err=1 (sticky), state goes to HALT, and no ack is given.
- Halt: halt_req sets halt_latched, which is sticky.
  - While latched, no new fetch is issued.
  - Pending or arriving data requests are still served.
  - HALT is entered from IDLE when there is no data request.
- HALT: halted=1, mem_req=0, all requests ignored, no acks. Exit is by reset only.
- The counter saturates and does not wrap. Width is clog2(MAX_WAIT+1), minimum 1.

Decomposition:
- Shared package holds:
  - state enum (IDLE, D_WAIT, I_WAIT, HALT);
  - DATA_W default;
  - MAX_WAIT default.
- Sub-module wait_timer: saturating counter with clr, en, expire=(count==MAX_WAIT)&&MAX_WAIT!=0.

Test Plan:
- Fetch only: if_addr=16'h0010, mem_ready 1 cycle after mem_req, mem_rdata=16'h4123 -> mem_req high cycle 1 only, if_ack cycle 2, if_rdata=16'h4123, stall_if=1 in cycles 0-1.
- Simultaneous: if_req and d_rd (d_addr=16'h0200, rdata 16'hBEEF) both in cycle 0 -> data served first with d_ack and d_rdata=16'hBEEF; fetch issued after; mem_addr sequence 0200 then if_addr.
- Write with 3-cycle memory latency, d_wr=1, d_addr=16'h0004, d_wdata=16'h00AA -> mem_wr=1, addr and data stable through all 3 cycles, single d_ack, d_rdata unchanged.
- Halt drain: halt_req pulse while D_WAIT, if_req held -> data completes, no further mem_req for fetch, halted=1 two cycles later and stays; if_ack never pulses.
- Timeout: MAX_WAIT=4, mem_ready never asserted -> mem_req high exactly 4 cycles, then err=1, halted=1, no ack.
- Reset mid-access: rst_n low during I_WAIT -> mem_req=0 immediately, all outputs 0. After release, a new fetch completes normally with err=0.

Source files
------------

// File: rtl/mem_port_sched_pkg.sv
// Shared types and defaults for the unified-memory port scheduler.
// Imported by the scheduler, its wait timer and the memory-bus interface.
package mem_port_sched_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int MAX_WAIT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2,
        HALT   = 2'd3
    } state_t;

    // Wait counter width; never narrower than one bit.
    function automatic int cnt_w(input int m);
        int w;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_port_sched_if.sv
// Request/ready bus between the port scheduler and the unified memory.
// Request, direction, address and write data are held while mem_req is high.
interface mem_port_sched_if
    import mem_port_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              mem_req;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/mem_port_sched_wait_timer.sv
// Saturating wait counter that flags a memory access running too long.
// A MAX_WAIT of zero disables expiry.
module mem_port_sched_wait_timer
    import mem_port_sched_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW  = cnt_w(MAX_WAIT);
    localparam logic [CW-1:0] LIM = CW'(MAX_WAIT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != LIM) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (MAX_WAIT != 0) && (count == LIM);

endmodule

// File: rtl/mem_port_sched.sv
// Shares the single-ported unified memory between fetch and the MEM stage.
// Data has priority, accesses are non-preemptive, HALT drains the machine.
module mem_port_sched
    import mem_port_sched_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    input  logic              halt_req,
    mem_port_sched_if.master  mem,
    output logic              stall_if,
    output logic              stall_d,
    output logic              halted,
    output logic              err
);

    state_t            state, state_n;
    logic              req_q, req_n;
    logic              wr_q, wr_n;
    logic [DATA_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [DATA_W-1:0] if_rdata_n, d_rdata_n;
    logic              if_ack_n, d_ack_n;
    logic              halted_n, err_n;
    logic              halt_lat, halt_lat_n;

    logic d_any, idle, d_go, f_go, h_go;
    logic waiting, done, t_en, t_clr, expire;

    assign d_any = d_rd | d_wr;

    // The ack cycle counts as busy: requesters still hold their lines.
    assign idle = (state == IDLE) & ~(if_ack | d_ack);
    assign d_go = idle & d_any;
    assign f_go = idle & ~d_any & if_req & ~halt_lat;
    assign h_go = idle & ~d_any & halt_lat;

    assign waiting = (state == D_WAIT) | (state == I_WAIT);
    assign done    = waiting & mem.mem_ready;

    // Counting starts at issue so mem_req stays up exactly MAX_WAIT cycles.
    assign t_en  = d_go | f_go | waiting;
    assign t_clr = ~t_en | done;

    mem_port_sched_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (t_clr),
        .en     (t_en),
        .expire (expire)
    );

    always_comb begin
        state_n    = state;
        req_n      = req_q;
        wr_n       = wr_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        if_rdata_n = if_rdata;
        d_rdata_n  = d_rdata;
        if_ack_n   = 1'b0;
        d_ack_n    = 1'b0;
        halted_n   = halted;
        err_n      = err;
        halt_lat_n = halt_lat | halt_req;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    d_go: begin
                        state_n = D_WAIT;
                        req_n   = 1'b1;
                        wr_n    = d_wr;
                        addr_n  = d_addr;
                        wdata_n = d_wdata;
                    end
                    f_go: begin
                        state_n = I_WAIT;
                        req_n   = 1'b1;
                        wr_n    = 1'b0;
                        addr_n  = if_addr;
                    end
                    h_go: begin
                        state_n  = HALT;
                        halted_n = 1'b1;
                    end
                    default: ;
                endcase
            end
            D_WAIT, I_WAIT: begin
                if (mem.mem_ready) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    if (state == D_WAIT) begin
                        d_ack_n = 1'b1;
                        if (!wr_q) d_rdata_n = mem.mem_rdata;
                    end else begin
                        if_ack_n   = 1'b1;
                        if_rdata_n = mem.mem_rdata;
                    end
                end else if (expire) begin
                    state_n  = HALT;
                    req_n    = 1'b0;
                    err_n    = 1'b1;
                    halted_n = 1'b1;
                end
            end
            HALT: begin
                req_n    = 1'b0;
                halted_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
            halt_lat <= 1'b0;
        end else begin
            state    <= state_n;
            req_q    <= req_n;
            wr_q     <= wr_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            if_rdata <= if_rdata_n;
            d_rdata  <= d_rdata_n;
            if_ack   <= if_ack_n;
            d_ack    <= d_ack_n;
            halted   <= halted_n;
            err      <= err_n;
            halt_lat <= halt_lat_n;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_wr    = wr_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign stall_if = if_req & ~if_ack;
    assign stall_d  = d_any & ~d_ack;

endmodule
